// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read/write/issue bus of the scoreboarded register file.
interface regfile_sb_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int NB_OF_REGS        = 32,
    parameter int ADDRESS_BIT_WIDTH = 5,
    parameter int NB_RD_PORTS       = 2
);
    logic                                      en;
    logic [NB_RD_PORTS*ADDRESS_BIT_WIDTH-1:0]  rd_addr;
    logic [NB_RD_PORTS*DATA_WIDTH-1:0]         rd_data;
    logic [NB_RD_PORTS-1:0]                    rd_busy;
    logic                                      we;
    logic [ADDRESS_BIT_WIDTH-1:0]              wa;
    logic [DATA_WIDTH-1:0]                     wd;
    logic                                      iss_valid;
    logic [ADDRESS_BIT_WIDTH-1:0]              iss_addr;
    logic                                      iss_ready;
    logic [NB_OF_REGS-1:0]                     busy_vec;
    logic                                      wb_unexp;
    modport master (
        output en, rd_addr, we, wa, wd, iss_valid, iss_addr,
        input  rd_data, rd_busy, iss_ready, busy_vec, wb_unexp
    );
    modport slave (
        input  en, rd_addr, we, wa, wd, iss_valid, iss_addr,
        output rd_data, rd_busy, iss_ready, busy_vec, wb_unexp
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, single-write register file with x0 = 0, optional
// write bypass and a per-register pending scoreboard for RAW/WAW detection.
module regfile_sb #(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    NB_OF_REGS        = 32,
    parameter int                    ADDRESS_BIT_WIDTH = 5,
    parameter int                    NB_RD_PORTS       = 2,
    parameter int                    BYPASS            = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE       = '0
) (
    input logic          clk,
    input logic          rst,
    regfile_sb_if.slave  bus
);
    localparam int AW = ADDRESS_BIT_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic [DW-1:0]         mem [1:NB_OF_REGS-1];
    logic [NB_OF_REGS-1:1] busy_r;
    logic [NB_OF_REGS-1:0] busy;
    logic                  wr_ok, clr, acc, iss_ok, unexp;

    assign busy   = {busy_r, 1'b0};
    assign wr_ok  = bus.we && bus.wa != '0 && int'(bus.wa) < NB_OF_REGS;
    assign clr    = wr_ok && busy[bus.wa];
    assign iss_ok = int'(bus.iss_addr) < NB_OF_REGS;
    // a clear landing this cycle does not release the stall until next cycle
    assign bus.iss_ready = bus.en && !rst && iss_ok && !busy[bus.iss_addr];
    assign acc      = bus.iss_valid && bus.iss_ready;
    assign bus.busy_vec = busy;
    assign bus.wb_unexp = unexp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NB_OF_REGS; i++) mem[i] <= RESET_VALUE;
            busy_r <= '0;
            unexp  <= 1'b0;
        end else if (bus.en) begin
            if (wr_ok) mem[bus.wa] <= bus.wd;
            // set has priority over clear on the same register
            for (int i = 1; i < NB_OF_REGS; i++)
                if (acc && int'(bus.iss_addr) == i) busy_r[i] <= 1'b1;
                else if (clr && int'(bus.wa) == i) busy_r[i] <= 1'b0;
            unexp <= wr_ok && !busy[bus.wa];
        end else begin
            unexp <= 1'b0;
        end
    end

    for (genvar k = 0; k < NB_RD_PORTS; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          ok, hit;
        assign a   = bus.rd_addr[k*AW +: AW];
        assign ok  = a != '0 && int'(a) < NB_OF_REGS;
        assign hit = BYPASS != 0 && bus.we && bus.wa == a;
        assign bus.rd_data[k*DW +: DW] = (!bus.en || rst || !ok) ? '0 : hit ? bus.wd : mem[a];
        assign bus.rd_busy[k] = bus.en && !rst && ok && busy[a] && !hit;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives a bypassing 32-register file and a non-bypassing
// 16-register file with identical stimulus and checks both against a model.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1, we = 1'b0, iss_valid = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [4:0]  wa = '0, iss_addr = '0;
    logic [31:0] wd = '0;
    int          pass = 0, total = 0;
    bit          started = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.NB_OF_REGS(32)) ifa ();
    regfile_sb_if #(.NB_OF_REGS(16)) ifb ();

    assign ifa.en = en;           assign ifb.en = en;
    assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;
    assign ifa.we = we;           assign ifb.we = we;
    assign ifa.wa = wa;           assign ifb.wa = wa;
    assign ifa.wd = wd;           assign ifb.wd = wd;
    assign ifa.iss_valid = iss_valid; assign ifb.iss_valid = iss_valid;
    assign ifa.iss_addr = iss_addr;   assign ifb.iss_addr = iss_addr;

    regfile_sb #(.NB_OF_REGS(32), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    regfile_sb #(.NB_OF_REGS(16), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [63:0] o_rd [2];
    logic [1:0]  o_rb [2];
    logic [31:0] o_bv [2];
    logic        o_ir [2], o_wu [2];
    assign o_rd[0] = ifa.rd_data;  assign o_rd[1] = ifb.rd_data;
    assign o_rb[0] = ifa.rd_busy;  assign o_rb[1] = ifb.rd_busy;
    assign o_bv[0] = ifa.busy_vec; assign o_bv[1] = {16'b0, ifb.busy_vec};
    assign o_ir[0] = ifa.iss_ready; assign o_ir[1] = ifb.iss_ready;
    assign o_wu[0] = ifa.wb_unexp; assign o_wu[1] = ifb.wb_unexp;

    // reference model: architectural contents, pending flags, diagnostic pulse
    logic [31:0] m_mem [2][32];
    bit          m_busy [2][32];
    bit          m_unexp [2];

    function automatic int nr(int j); return j == 0 ? 32 : 16; endfunction
    function automatic bit bp(int j); return j == 0; endfunction

    function automatic logic [31:0] e_data(int j, int a);
        if (!en || rst || a == 0 || a >= nr(j)) return 32'h0;
        if (bp(j) && we && int'(wa) == a) return wd;
        return m_mem[j][a];
    endfunction
    function automatic bit e_rbusy(int j, int a);
        if (!en || rst || a == 0 || a >= nr(j)) return 1'b0;
        return m_busy[j][a] && !(bp(j) && we && int'(wa) == a);
    endfunction
    function automatic bit e_ready(int j);
        return en && !rst && int'(iss_addr) < nr(j) && !m_busy[j][iss_addr];
    endfunction
    function automatic logic [31:0] e_bv(int j);
        logic [31:0] v = '0;
        for (int i = 1; i < nr(j); i++) v[i] = m_busy[j][i];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin m_mem[j][i] = 32'h0; m_busy[j][i] = 1'b0; end
                m_unexp[j] = 1'b0;
            end else if (en) begin
                bit wr, accept;
                wr = we && wa != 0 && int'(wa) < nr(j);
                accept = iss_valid && e_ready(j);
                m_unexp[j] = wr && !m_busy[j][wa];
                if (wr) begin m_busy[j][wa] = 1'b0; m_mem[j][wa] = wd; end
                if (accept && iss_addr != 0) m_busy[j][iss_addr] = 1'b1;
            end else begin
                m_unexp[j] = 1'b0;
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else pass++;
    endtask

    always @(negedge clk) begin
        int a;
        if (started)
            for (int j = 0; j < 2; j++) begin
                for (int k = 0; k < 2; k++) begin
                    a = int'(rd_addr[k*5 +: 5]);
                    chk($sformatf("rd_data%0d_p%0d", j, k), 64'(o_rd[j][k*32 +: 32]), 64'(e_data(j, a)));
                    chk($sformatf("rd_busy%0d_p%0d", j, k), 64'(o_rb[j][k]), 64'(e_rbusy(j, a)));
                end
                chk($sformatf("iss_ready%0d", j), 64'(o_ir[j]), 64'(e_ready(j)));
                chk($sformatf("busy_vec%0d", j), 64'(o_bv[j]), 64'(e_bv(j)));
                chk($sformatf("wb_unexp%0d", j), 64'(o_wu[j]), 64'(m_unexp[j]));
            end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        started = 1;
        chk("reset_busy_vec", 64'(ifa.busy_vec), 64'h0);
        chk("reset_iss_ready", 64'(ifa.iss_ready), 64'h0);
        rst = 1'b0;
        step();
        // write x5, then reset asynchronously in the middle of a cycle
        we = 1; wa = 5; wd = 32'h1234; rd_addr = {5'd0, 5'd5};
        step();
        we = 0; #1;
        chk("x5_written", 64'(ifa.rd_data[31:0]), 64'h1234);
        chk("x5_unexp", 64'(ifa.wb_unexp), 64'h1);
        #2 rst = 1'b1; #1;
        chk("rst_mid_rd", 64'(ifa.rd_data), 64'h0);
        chk("rst_mid_ready", 64'(ifb.iss_ready), 64'h0);
        step(); rst = 1'b0; step();
        chk("x5_after_rst", 64'(ifa.rd_data[31:0]), 64'h0);
        chk("busy_after_rst", 64'(ifa.busy_vec), 64'h0);
        // x0 protection
        we = 1; wa = 0; wd = 32'hDEADBEEF; rd_addr = '0;
        step();
        we = 0; #1;
        chk("x0_rd", 64'(ifa.rd_data), 64'h0);
        chk("x0_unexp", 64'(ifa.wb_unexp), 64'h0);
        // bypass vs no bypass
        we = 1; wa = 9; wd = 32'h2004; rd_addr = {5'd0, 5'd9}; #1;
        chk("bypass_same_cycle", 64'(ifa.rd_data[31:0]), 64'h2004);
        chk("nobypass_same_cycle", 64'(ifb.rd_data[31:0]), 64'h0);
        step();
        we = 0; #1;
        chk("nobypass_next_cycle", 64'(ifb.rd_data[31:0]), 64'h2004);
        // scoreboard flow on x7
        iss_valid = 1; iss_addr = 7; #1;
        chk("x7_ready", 64'(ifa.iss_ready), 64'h1);
        step();
        rd_addr = {5'd7, 5'd9}; #1;
        chk("x7_busy_vec", 64'(ifa.busy_vec[7]), 64'h1);
        chk("x7_rd_busy", 64'(ifa.rd_busy[1]), 64'h1);
        chk("x7_waw_stall", 64'(ifb.iss_ready), 64'h0);
        iss_valid = 0; we = 1; wa = 7; wd = 32'h55; #1;
        chk("x7_bypass_not_busy", 64'(ifa.rd_busy[1]), 64'h0);
        chk("x7_nobypass_busy", 64'(ifb.rd_busy[1]), 64'h1);
        step();
        we = 0; #1;
        chk("x7_cleared", 64'(ifa.busy_vec[7]), 64'h0);
        chk("x7_ready_again", 64'(ifa.iss_ready), 64'h1);
        chk("x7_no_unexp", 64'(ifa.wb_unexp), 64'h0);
        // x3: stall, clear without early release, then issue with a write
        iss_valid = 1; iss_addr = 3; step();
        we = 1; wa = 3; wd = 32'h33; #1;
        chk("x3_stall_on_clear", 64'(ifa.iss_ready), 64'h0);
        step();
        wd = 32'h34; #1;
        chk("x3_released", 64'(ifa.iss_ready), 64'h1);
        step();
        iss_valid = 0; #1;
        chk("x3_set_wins", 64'(ifa.busy_vec[3]), 64'h1);
        chk("x3_unexp", 64'(ifb.wb_unexp), 64'h1);
        step();
        // unexpected write to x4 gives a single-cycle pulse
        wa = 4; wd = 32'h44; step();
        we = 0; #1;
        chk("x4_pulse", 64'(ifa.wb_unexp), 64'h1);
        step();
        chk("x4_pulse_end", 64'(ifa.wb_unexp), 64'h0);
        // enable gating on x2
        we = 1; wa = 2; wd = 32'h77; step();
        en = 0; wd = 32'hA; iss_valid = 1; iss_addr = 2; rd_addr = {5'd2, 5'd2}; #1;
        chk("en0_rd", 64'(ifa.rd_data), 64'h0);
        chk("en0_ready", 64'(ifa.iss_ready), 64'h0);
        step();
        en = 1; we = 0; iss_valid = 0; #1;
        chk("en1_x2_held", 64'(ifa.rd_data[31:0]), 64'h77);
        chk("en1_x2_not_busy", 64'(ifa.busy_vec[2]), 64'h0);
        chk("en1_no_unexp", 64'(ifa.wb_unexp), 64'h0);
        // out-of-range for the 16-register instance
        we = 1; wa = 20; wd = 32'hCAFE; step();
        we = 0; rd_addr = {5'd20, 5'd20}; iss_addr = 20; #1;
        chk("oor_rd_b", 64'(ifb.rd_data), 64'h0);
        chk("oor_rd_a", 64'(ifa.rd_data[31:0]), 64'hCAFE);
        chk("oor_ready_b", 64'(ifb.iss_ready), 64'h0);
        chk("oor_ready_a", 64'(ifa.iss_ready), 64'h1);
        // sweep writes while issuing and reading across registers
        for (int i = 1; i < 8; i++) begin
            we = 1; wa = 5'(i + 8); wd = 32'(i * 32'h111);
            iss_valid = i[0]; iss_addr = 5'(i + 9);
            rd_addr = {5'(i + 9), 5'(i + 7)};
            step();
        end
        we = 0; iss_valid = 0; step(); step();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
